// File: rtl/shared_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arbiter_pkg
// Description : Shared definitions for the shared-register arbiter.
//               FSM state encoding, default parameter values and the
//               round-robin rotate-and-priority-encode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package shared_reg_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int NREQ_DEF     = 4;
  localparam int WIDTH_DEF    = 8;
  localparam int MAX_HOLD_DEF = 8;

  // Widest requester vector the helper supports.
  localparam int RR_MAX = 8;

  // Scan req starting at ptr, upward with wrap at n-1 -> 0.
  // Returns {found, index}. Only the low n bits of req are considered.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic [3:0] res;
    res = 4'b0000;
    for (int k = 0; k < RR_MAX; k++) begin
      int         idx;
      logic [2:0] idx3;
      idx  = (int'(ptr) + k) % n;
      idx3 = 3'(idx);
      if ((k < n) && !res[3] && req[idx3]) begin
        res = {1'b1, idx3};
      end
    end
    return res;
  endfunction

endpackage : shared_reg_arbiter_pkg
`default_nettype wire

// File: rtl/shared_dreg.sv
`default_nettype none
// ============================================================================
// Module      : shared_dreg
// Description : WIDTH-bit D register with load enable and synchronous
//               active-high reset to zero; provides q and its complement.
// Ports       : Clk   - clock
//               Reset - synchronous active-high reset
//               load  - load enable
//               d     - data input
//               q     - register contents
//               qbar  - bitwise complement of q (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module shared_dreg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

  assign qbar = ~q;

endmodule : shared_dreg
`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arbiter
// Description : Round-robin arbiter sharing one WIDTH-bit holding register
//               among NREQ requesters, with ownership capped at MAX_HOLD
//               cycles.
// Ports       : Clk     - clock
//               Reset   - synchronous active-high reset
//               req     - per-requester request
//               wr_en   - per-requester write strobe
//               wr_data - flattened write data, requester i at [i*WIDTH +: WIDTH]
//               gnt     - registered one-hot grant
//               owner   - index of current owner (valid while busy)
//               busy    - high while a grant is held
//               q/qbar  - shared register contents and complement
//               denied  - one-cycle pulse after a non-owner write attempt
// Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int OW       = $clog2(NREQ)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr_en,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [OW-1:0]         owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar,
  output logic                  denied
);

  localparam int HW = $clog2(MAX_HOLD);

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [HW-1:0]   hold_cnt;

  logic [3:0]      pick;
  logic [OW-1:0]   winner;
  logic [NREQ-1:0] nonowner;
  logic            wr_load;
  logic [WIDTH-1:0] wr_d;

  assign pick   = rr_pick(8'(req), 3'(rr_ptr), NREQ);
  assign winner = OW'(pick[2:0]);

  // In IDLE every requester counts as a non-owner.
  assign nonowner = (state == ST_GRANT) ? ~gnt : '1;

  // Owner mux into the shared register; only the owner can load, and only
  // while granted (including the release edge).
  assign wr_load = (state == ST_GRANT) && wr_en[owner];
  assign wr_d    = wr_data[int'(owner)*WIDTH +: WIDTH];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      denied   <= 1'b0;
    end else begin
      denied <= |(wr_en & nonowner);
      case (state)
        ST_IDLE: begin
          if (pick[3]) begin
            state    <= ST_GRANT;
            gnt      <= NREQ'(1) << winner;
            owner    <= winner;
            busy     <= 1'b1;
            rr_ptr   <= OW'((int'(winner) + 1) % NREQ);
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          // Voluntary release or hold-limit expiry both return to IDLE,
          // which guarantees one idle cycle between ownerships.
          if (!req[owner] || (hold_cnt == HW'(MAX_HOLD - 1))) begin
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  shared_dreg #(
    .WIDTH (WIDTH)
  ) u_dreg (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (wr_load),
    .d     (wr_d),
    .q     (q),
    .qbar  (qbar)
  );

endmodule : shared_reg_arbiter
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_reg_arbiter
// Description : Directed self-checking bench for shared_reg_arbiter
//               (NREQ=4, WIDTH=8, MAX_HOLD=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_reg_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 8;

  logic                  Clk;
  logic                  Reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       wr_en;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       gnt;
  logic [1:0]            owner;
  logic                  busy;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic                  denied;

  int n_total;
  int n_pass;

  shared_reg_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     (req),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .q       (q),
    .qbar    (qbar),
    .denied  (denied)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    wr_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    req   = '0;
    wr_en = '0;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // ---------------- reset with garbage inputs ----------------
    Reset   = 1'b1;
    req     = 4'b1111;
    wr_en   = 4'b1111;
    wr_data = 32'hDEADBEEF;
    tick();
    tick();
    check("rst_gnt",    32'(gnt),    32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_owner",  32'(owner),  32'h0);
    check("rst_q",      32'(q),      32'h00);
    check("rst_qbar",   32'(qbar),   32'hFF);
    check("rst_denied", 32'(denied), 32'h0);
    Reset = 1'b0;
    req   = '0;
    wr_en = '0;
    wr_data = '0;
    tick();

    // ---------------- basic grant and write ----------------
    req = 4'b0001;
    tick();
    check("basic_gnt",   32'(gnt),   32'h1);
    check("basic_busy",  32'(busy),  32'h1);
    check("basic_owner", 32'(owner), 32'h0);
    wr_en = 4'b0001;
    set_data(0, 8'hA5);
    tick();
    check("basic_q",      32'(q),      32'hA5);
    check("basic_qbar",   32'(qbar),   32'h5A);
    check("basic_denied", 32'(denied), 32'h0);
    wr_en = '0;
    req   = '0;
    tick();
    check("basic_rel_gnt",  32'(gnt),  32'h0);
    check("basic_rel_busy", 32'(busy), 32'h0);
    check("basic_q_hold",   32'(q),    32'hA5);

    // ---------------- round robin 0,1,2,3,0 ----------------
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % NREQ;
      check($sformatf("rr%0d_gnt_a", k), 32'(gnt),   32'(1 << e));
      check($sformatf("rr%0d_owner", k), 32'(owner), 32'(e));
      tick();
      check($sformatf("rr%0d_gnt_b", k), 32'(gnt),   32'(1 << e));
      req[e] = 1'b0;
      tick();
      check($sformatf("rr%0d_idle", k),  32'(gnt),   32'h0);
      req = 4'b1111;
      tick();
    end
    req = '0;
    tick();
    check("rr_end_idle", 32'(gnt), 32'h0);

    // ---------------- forced release ----------------
    do_reset();
    req = 4'b0011;
    tick();
    for (int i = 0; i < MAX_HOLD; i++) begin
      check($sformatf("hold_c%0d", i), 32'(gnt), 32'h1);
      tick();
    end
    check("hold_idle",   32'(gnt), 32'h0);
    tick();
    check("hold_next",   32'(gnt), 32'h2);
    check("hold_owner",  32'(owner), 32'h1);
    req = '0;
    tick();

    // ---------------- denied writes ----------------
    do_reset();
    req = 4'b0001;
    tick();
    check("den_gnt", 32'(gnt), 32'h1);
    wr_en = 4'b0101;
    set_data(0, 8'h3C);
    set_data(2, 8'hFF);
    tick();
    check("den_q",      32'(q),      32'h3C);
    check("den_pulse",  32'(denied), 32'h1);
    wr_en = '0;
    tick();
    check("den_clear",  32'(denied), 32'h0);
    check("den_q_hold", 32'(q),      32'h3C);
    req = '0;
    tick();
    check("den_idle", 32'(gnt), 32'h0);
    wr_en = 4'b0010;
    set_data(1, 8'h99);
    tick();
    check("idle_den_pulse", 32'(denied), 32'h1);
    check("idle_den_q",     32'(q),      32'h3C);
    wr_en = '0;
    tick();
    check("idle_den_clear", 32'(denied), 32'h0);

    // write coinciding with release still lands
    req = 4'b0001;
    tick();
    check("relw_gnt", 32'(gnt), 32'h1);
    req   = '0;
    wr_en = 4'b0001;
    set_data(0, 8'h5E);
    tick();
    check("relw_gnt0", 32'(gnt), 32'h0);
    check("relw_q",    32'(q),   32'h5E);
    wr_en = '0;
    tick();

    // ---------------- reset mid-ownership ----------------
    do_reset();
    req = 4'b0010;
    tick();
    check("mrst_gnt",   32'(gnt),   32'h2);
    check("mrst_owner", 32'(owner), 32'h1);
    wr_en = 4'b0010;
    set_data(1, 8'h77);
    Reset = 1'b1;
    tick();
    check("mrst_q",    32'(q),    32'h00);
    check("mrst_gnt0", 32'(gnt),  32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    Reset = 1'b0;
    wr_en = '0;
    tick();
    check("mrst_regnt", 32'(gnt),   32'h2);
    check("mrst_q2",    32'(q),     32'h00);
    req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_shared_reg_arbiter
`default_nettype wire

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-flip-flop holding register between NREQ requesters.
- A requester raises req and receives a one-hot registered grant. While granted, it alone may load the register.
- Ownership is capped at MAX_HOLD cycles so that no requester can starve the others.
- The block sits between requester-side logic and the shared storage register, which it instantiates.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, shared register width.
- MAX_HOLD, 8, maximum consecutive cycles one owner may keep the grant (>=2).

Ports:
- Clk  input  1  single clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- req  input  NREQ  request bit per requester; held high for the whole ownership.
- wr_en  input  NREQ  per-requester write strobe.
- wr_data  input  NREQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  registered one-hot grant, all-zero when idle.
- owner  output  clog2(NREQ)  index of the current owner; valid only while busy=1.
- busy  output  1  high while state is GRANT.
- q  output  WIDTH  shared register contents.
- qbar  output  WIDTH  bitwise complement of q (combinational).
- denied  output  1  registered one-cycle pulse when any non-owner asserts wr_en.

Behaviour:
- Reset, sampled high on a rising Clk edge, applies these values at that edge: state=IDLE, gnt=0, owner=0, busy=0, q=0 (so qbar=all ones), denied=0, rr_ptr=0, hold_cnt=0.
- Reset has priority over every other event, including a write or an arbitration in the same cycle.
- Reset asserted mid-ownership drops the grant and clears q at that edge. Pending requests re-arbitrate after Reset deasserts.
- FSM states: IDLE, GRANT.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set: pick the winner by scanning from rr_ptr upward with wrap, index NREQ-1 -> 0. On that edge: gnt=onehot(winner), owner=winner, rr_ptr=(winner+1) mod NREQ, hold_cnt=0, go to GRANT. Latency: req high in cycle N (state IDLE) gives gnt visible in cycle N+1.
- GRANT, req[owner]=0: at the next edge, gnt=0 and state=IDLE. Minimum one IDLE cycle between ownerships. A new grant appears no earlier than 2 cycles after release.
- GRANT, req[owner]=1 and hold_cnt=MAX_HOLD-1: forced release. gnt=0 and state=IDLE at that edge, so the owner holds gnt for exactly MAX_HOLD cycles. rr_ptr already points past the old owner, so other requesters win next. If no one else requests, the old owner is re-granted after the IDLE cycle.
- GRANT, otherwise: hold_cnt increments.
- Write: in GRANT with wr_en[owner]=1, q takes wr_data[owner] at the same edge. The new value is visible in the following cycle, i.e. 1-cycle write latency.
- A write coinciding with release or forced release still takes effect in that cycle.
- No write occurs in IDLE. q holds its value whenever no valid write happens.
- denied: next cycle high if any wr_en[i]=1 with i != owner, or with state=IDLE. Such writes never modify q. Simultaneous valid owner write and denied writes: the owner write is performed and denied pulses.
- Single requester with req held continuously: granted MAX_HOLD cycles, 1 IDLE cycle, re-granted, repeating.
- Invariants: gnt always one-hot or zero; popcount(gnt)<=1; busy == |gnt.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE, ST_GRANT) and default values NREQ_DEF, WIDTH_DEF, MAX_HOLD_DEF.
- Helper function for the round-robin rotate-and-priority-encode.
- One sub-module, shared_dreg: a WIDTH-bit D register with load enable, synchronous active-high Reset to 0, and q/qbar outputs. The arbiter drives its D input and load enable from the owner mux.

Test Plan:
- Reset: drive garbage on all inputs, assert Reset 2 cycles -> gnt=0000, busy=0, q=8'h00, qbar=8'hFF, denied=0.
- Basic grant and write: req=0001 in cycle 0 -> gnt=0001 in cycle 1; wr_en=0001, wr_data[0]=8'hA5 in cycle 2 -> q=8'hA5, qbar=8'h5A in cycle 3; drop req -> gnt=0000 the next cycle.
- Round-robin: req=1111 held with each owner releasing after 2 cycles -> grant order 0,1,2,3,0, with one IDLE cycle between each.
- Forced release: req=0011 held continuously, MAX_HOLD=8 -> gnt=0001 for exactly 8 cycles, 1 IDLE cycle, then gnt=0010.
- Denied write: owner=0 writes 8'h3C while requester 2 asserts wr_en with data 8'hFF -> q=8'h3C and denied=1 for one cycle. wr_en with no owner (IDLE) -> q unchanged, denied=1.
- Reset mid-ownership: owner=1 writing 8'h77 in the same cycle Reset=1 -> q=8'h00, gnt=0000. After Reset falls with req=0010 still held -> gnt=0010 one cycle later.
